// File: rtl/ne16_store_packer.sv
// ne16_store_packer: packs LSB-contiguous partial-strobe beats into dense DW-bit words; flush emits the residual.
// Define NE16_STORE_PACKER_BYTECNT_EN to build the emitted-byte counter behind byte_cnt_o.
module ne16_store_packer #(
    parameter int DW = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic                       flush_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic [DW/8-1:0]            push_strb_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    output logic [DW-1:0]              pop_data_o,
    output logic [DW/8-1:0]            pop_strb_o,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [$clog2(DW/8)-1:0]    pending_o,
    output logic                       busy_o,
    output logic                       flush_done_o,
    output logic                       strb_err_o,
    output logic [31:0]                byte_cnt_o
);
    localparam int NB = DW / 8;
    localparam int CW = $clog2(NB);

    typedef enum logic [1:0] {PACK, FLUSH, DONE} state_e;
    state_e          state_q, state_d;
    logic [DW-1:0]   res_q, res_d, out_data_q, out_data_d, new_m;
    logic [NB-1:0]   out_strb_q, out_strb_d;
    logic [CW-1:0]   pend_q, pend_d;
    logic            out_valid_q, out_valid_d, flush_req_q, flush_req_d, err_q, err_d;
    logic [CW:0]     n, sum;
    logic [2*DW-1:0] wide;
    logic            contig, acc, good, full, pop_hs, out_free, flush_load;

    always_comb begin
        for (int i = 0; i < NB; i++) new_m[i*8 +: 8] = push_data_i[i*8 +: 8] & {8{push_strb_i[i]}};
    end

    assign n        = (CW+1)'($countones(push_strb_i));
    assign contig   = ~|(push_strb_i & (push_strb_i + NB'(1)));
    assign sum      = {1'b0, pend_q} + n;
    assign full     = sum[CW];
    // upper half of the shifted concat is what spills into the next word
    assign wide     = {{DW{1'b0}}, res_q} | ({{DW{1'b0}}, new_m} << {pend_q, 3'b000});
    assign pop_hs   = enable_i & out_valid_q & pop_ready_i;
    assign out_free = ~out_valid_q | pop_hs;
    assign acc      = push_valid_i & push_ready_o;
    assign good     = acc & contig;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= PACK;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (enable_i) begin
            case (state_q)
                PACK:    state_d = ((flush_req_q | flush_i) & ~acc) ? FLUSH : PACK;
                FLUSH:   state_d = out_free ? DONE : FLUSH;
                DONE:    state_d = out_valid_q ? DONE : PACK;
                default: state_d = PACK;
            endcase
        end
        if (clear_i) state_d = PACK;
    end

    always_comb begin
        push_ready_o = enable_i & (state_q == PACK) & out_free;
        flush_load   = enable_i & (state_q == FLUSH) & out_free & (pend_q != '0);
        flush_done_o = enable_i & (state_q == DONE) & ~out_valid_q;
    end

    always_comb begin
        res_d       = res_q;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_valid_d = out_valid_q & ~pop_hs;
        err_d       = err_q | (acc & ~contig);
        flush_req_d = flush_done_o ? 1'b0 : (flush_req_q | (flush_i & (state_q == PACK)));
        if (good) begin
            res_d  = full ? wide[2*DW-1:DW] : wide[DW-1:0];
            pend_d = sum[CW-1:0];
        end
        if (good & full) begin
            out_data_d  = wide[DW-1:0];
            out_strb_d  = '1;
            out_valid_d = 1'b1;
        end
        if (flush_load) begin
            out_data_d  = res_q;
            out_strb_d  = (NB'(1) << pend_q) - NB'(1);
            out_valid_d = 1'b1;
            res_d       = '0;
            pend_d      = '0;
        end
        if (clear_i) begin
            res_d       = '0;
            pend_d      = '0;
            out_data_d  = '0;
            out_strb_d  = '0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            flush_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q       <= '0;
            pend_q      <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            flush_req_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            flush_req_q <= flush_req_d;
        end
    end

    assign pop_data_o  = out_data_q;
    assign pop_strb_o  = out_strb_q;
    assign pop_valid_o = out_valid_q & enable_i;
    assign pending_o   = pend_q;
    assign strb_err_o  = err_q;
    assign busy_o      = (pend_q != '0) | out_valid_q | flush_req_q | (state_q != PACK);

`ifdef NE16_STORE_PACKER_BYTECNT_EN
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d = clear_i ? 32'd0 : cnt_q + (pop_hs ? 32'($countones(out_strb_q)) : 32'd0);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign byte_cnt_o = cnt_q;
`else
    assign byte_cnt_o = '0;
`endif
endmodule
